// File: rtl/tconv_tile_sequencer.sv
// Tile control sequencer for the transpose-convolution datapath: weight fetch, per-channel ifmap reads,
// compute enables and column drain. Optional busy-cycle counter enabled by TCONV_SEQ_PERF_EN.
module tconv_tile_sequencer #(
    parameter int NUM_BRAMS = 16,
    parameter int W_ADDR_W  = 10,
    parameter int I_ADDR_W  = 10,
    parameter int READ_LAT  = 1,
    parameter int SEL_W     = $clog2(NUM_BRAMS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [W_ADDR_W-1:0]           cfg_w_base,
    input  logic [I_ADDR_W-1:0]           cfg_if_base,
    input  logic [I_ADDR_W-1:0]           cfg_len,
    input  logic [SEL_W:0]                cfg_num_ch,
    input  logic                          hold,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_BRAMS-1:0]          w_re,
    output logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_rd_flat,
    output logic [NUM_BRAMS-1:0]          if_re,
    output logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_rd_flat,
    output logic [SEL_W-1:0]              ifmap_sel,
    output logic [NUM_BRAMS-1:0]          en_weight_load,
    output logic [NUM_BRAMS-1:0]          en_ifmap_load,
    output logic [NUM_BRAMS-1:0]          en_psum,
    output logic [NUM_BRAMS-1:0]          clear_psum,
    output logic [NUM_BRAMS-1:0]          en_output,
    output logic [SEL_W:0]                done_select,
    output logic [31:0]                   perf_cycles
);

    localparam int LAT_W = 3;
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0]     LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [I_ADDR_W-1:0]  I_ONE    = {{(I_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]     SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]       NCH_ONE  = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]     K_LAST   = SEL_W'(NUM_BRAMS - 1);
    localparam logic [NUM_BRAMS-1:0] ALL_ONES = {NUM_BRAMS{1'b1}};
    localparam logic [NUM_BRAMS-1:0] ZEROS    = {NUM_BRAMS{1'b0}};
    localparam logic [NUM_BRAMS-1:0] ONE_HOT0 = {{(NUM_BRAMS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_WAIT_W = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                state_r, state_s;
    logic [SEL_W-1:0]      ch_r, ch_s, k_r, k_s;
    logic [I_ADDR_W-1:0]   i_r, i_s;
    logic [LAT_W-1:0]      lat_r, lat_s;
    logic [W_ADDR_W-1:0]   w_base_r, w_base_s, w_addr_r, w_addr_s;
    logic [I_ADDR_W-1:0]   if_base_r, if_base_s, len_r, len_s, if_addr_r, if_addr_s;
    logic [SEL_W:0]        num_ch_r, num_ch_s, dsel_r, dsel_s;
    logic [SEL_W-1:0]      sel_r, sel_s;
    logic                  busy_r, busy_s, done_r, done_s;
    logic [NUM_BRAMS-1:0]  w_re_r, w_re_s, if_re_r, if_re_s;
    logic [NUM_BRAMS-1:0]  ewl_r, ewl_s, eil_r, eil_s, eps_r, eps_s, clr_r, clr_s, eout_r, eout_s;
    logic                  issue_s, drain_s;

    // Next-state, counter and next-output decode; outputs for the coming cycle are registered below.
    always_comb begin
        state_s   = state_r;
        ch_s      = ch_r;
        k_s       = k_r;
        i_s       = i_r;
        lat_s     = lat_r;
        w_base_s  = w_base_r;
        if_base_s = if_base_r;
        len_s     = len_r;
        num_ch_s  = num_ch_r;
        w_addr_s  = w_addr_r;
        if_addr_s = if_addr_r;
        sel_s     = sel_r;
        dsel_s    = dsel_r;
        done_s    = 1'b0;
        w_re_s    = ZEROS;
        if_re_s   = ZEROS;
        ewl_s     = ZEROS;
        eil_s     = ZEROS;
        eps_s     = ZEROS;
        clr_s     = ZEROS;
        eout_s    = ZEROS;
        issue_s   = 1'b0;
        drain_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    w_base_s  = cfg_w_base;
                    if_base_s = cfg_if_base;
                    len_s     = cfg_len;
                    num_ch_s  = cfg_num_ch;
                    if ((cfg_len == {I_ADDR_W{1'b0}}) || (cfg_num_ch == {(SEL_W+1){1'b0}})) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s  = ST_LOAD_W;
                        w_re_s   = ALL_ONES;
                        w_addr_s = cfg_w_base;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                state_s = ST_WAIT_W;
                lat_s   = {LAT_W{1'b0}};
                ewl_s   = (lat_s == LAT_LAST) ? ALL_ONES : ZEROS;
            end
            ST_WAIT_W: begin
                if (lat_r == LAT_LAST) begin
                    ch_s    = {SEL_W{1'b0}};
                    i_s     = {I_ADDR_W{1'b0}};
                    issue_s = 1'b1;
                end else begin
                    lat_s = lat_r + LAT_ONE;
                    ewl_s = (lat_s == LAT_LAST) ? ALL_ONES : ZEROS;
                end
            end
            ST_READ: begin
                // A read overlapped by hold is dropped and reissued once hold clears.
                if (hold) begin
                    state_s = ST_READ;
                end else if (|if_re_r) begin
                    state_s = ST_WAIT;
                    lat_s   = {LAT_W{1'b0}};
                    eil_s   = (lat_s == LAT_LAST) ? ALL_ONES : ZEROS;
                    eps_s   = eil_s;
                end else begin
                    issue_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_r == LAT_LAST) begin
                    k_s     = {SEL_W{1'b0}};
                    drain_s = 1'b1;
                end else begin
                    lat_s = lat_r + LAT_ONE;
                    eil_s = (lat_s == LAT_LAST) ? ALL_ONES : ZEROS;
                    eps_s = eil_s;
                end
            end
            ST_DRAIN: begin
                if (hold) begin
                    state_s = ST_DRAIN;
                end else if (k_r != K_LAST) begin
                    k_s     = k_r + SEL_ONE;
                    drain_s = 1'b1;
                end else if (i_r != (len_r - I_ONE)) begin
                    i_s     = i_r + I_ONE;
                    issue_s = 1'b1;
                end else if ({1'b0, ch_r} != (num_ch_r - NCH_ONE)) begin
                    ch_s    = ch_r + SEL_ONE;
                    i_s     = {I_ADDR_W{1'b0}};
                    issue_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            state_s   = ST_READ;
            if_re_s   = ONE_HOT0 << ch_s;
            if_addr_s = if_base_r + i_s;
            sel_s     = ch_s;
            clr_s     = ALL_ONES;
        end else begin
            if_re_s = if_re_s;
        end
        if (drain_s) begin
            state_s = ST_DRAIN;
            eout_s  = ONE_HOT0 << k_s;
            dsel_s  = {1'b0, k_s};
        end else begin
            eout_s = eout_s;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ch_r      <= {SEL_W{1'b0}};
            k_r       <= {SEL_W{1'b0}};
            i_r       <= {I_ADDR_W{1'b0}};
            lat_r     <= {LAT_W{1'b0}};
            w_base_r  <= {W_ADDR_W{1'b0}};
            if_base_r <= {I_ADDR_W{1'b0}};
            len_r     <= {I_ADDR_W{1'b0}};
            num_ch_r  <= {(SEL_W+1){1'b0}};
            w_addr_r  <= {W_ADDR_W{1'b0}};
            if_addr_r <= {I_ADDR_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            dsel_r    <= {(SEL_W+1){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_re_r    <= ZEROS;
            if_re_r   <= ZEROS;
            ewl_r     <= ZEROS;
            eil_r     <= ZEROS;
            eps_r     <= ZEROS;
            clr_r     <= ZEROS;
            eout_r    <= ZEROS;
        end else begin
            state_r   <= state_s;
            ch_r      <= ch_s;
            k_r       <= k_s;
            i_r       <= i_s;
            lat_r     <= lat_s;
            w_base_r  <= w_base_s;
            if_base_r <= if_base_s;
            len_r     <= len_s;
            num_ch_r  <= num_ch_s;
            w_addr_r  <= w_addr_s;
            if_addr_r <= if_addr_s;
            sel_r     <= sel_s;
            dsel_r    <= dsel_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            w_re_r    <= w_re_s;
            if_re_r   <= if_re_s;
            ewl_r     <= ewl_s;
            eil_r     <= eil_s;
            eps_r     <= eps_s;
            clr_r     <= clr_s;
            eout_r    <= eout_s;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign w_re            = w_re_r;
    assign w_addr_rd_flat  = {NUM_BRAMS{w_addr_r}};
    assign if_re           = if_re_r;
    assign if_addr_rd_flat = {NUM_BRAMS{if_addr_r}};
    assign ifmap_sel       = sel_r;
    assign en_weight_load  = ewl_r;
    assign en_ifmap_load   = eil_r;
    assign en_psum         = eps_r;
    assign clear_psum      = clr_r;
    assign en_output       = eout_r;
    assign done_select     = dsel_r;

`ifdef TCONV_SEQ_PERF_EN
    logic [31:0] perf_r;

    // Busy cycles preceding DONE; value is frozen from DONE until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            perf_r <= 32'd0;
        end else if ((state_r != ST_IDLE) && (state_r != ST_DONE) && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tconv_tile_sequencer.sv
// Scoreboard bench for tconv_tile_sequencer: a tile-level model queues expected strobe events,
// a negedge monitor pops and compares every cycle in which the DUT drives a strobe or done.
module tb_tconv_tile_sequencer;

    localparam int NB = 16;
    localparam int WA = 10;
    localparam int IA = 10;
    localparam int RL = 1;
    localparam int SW = 4;
    localparam int E  = 1 + RL + NB;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [WA-1:0]     cfg_w_base = '0;
    logic [IA-1:0]     cfg_if_base = '0;
    logic [IA-1:0]     cfg_len = '0;
    logic [SW:0]       cfg_num_ch = '0;
    logic              busy, done;
    logic [NB-1:0]     w_re, if_re, en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output;
    logic [NB*WA-1:0]  w_addr_rd_flat;
    logic [NB*IA-1:0]  if_addr_rd_flat;
    logic [SW-1:0]     ifmap_sel;
    logic [SW:0]       done_select;
    logic [31:0]       perf_cycles;

    tconv_tile_sequencer #(.NUM_BRAMS(NB), .W_ADDR_W(WA), .I_ADDR_W(IA), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_w_base(cfg_w_base), .cfg_if_base(cfg_if_base),
        .cfg_len(cfg_len), .cfg_num_ch(cfg_num_ch), .hold(hold), .busy(busy), .done(done),
        .w_re(w_re), .w_addr_rd_flat(w_addr_rd_flat), .if_re(if_re), .if_addr_rd_flat(if_addr_rd_flat),
        .ifmap_sel(ifmap_sel), .en_weight_load(en_weight_load), .en_ifmap_load(en_ifmap_load),
        .en_psum(en_psum), .clear_psum(clear_psum), .en_output(en_output), .done_select(done_select),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               cyc;
        logic [NB-1:0]    w_re;
        logic [NB*WA-1:0] w_flat;
        logic [NB-1:0]    if_re;
        logic [NB*IA-1:0] if_flat;
        logic [SW-1:0]    sel;
        logic [NB-1:0]    ewl, eil, eps, clr, eout;
        logic [SW:0]      dsel;
        logic             done;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  done_cnt = 0;
    int  last_done_cyc = -1;
    logic any_out;

    assign any_out = |{busy, done, w_re, w_addr_rd_flat, if_re, if_addr_rd_flat, ifmap_sel, en_weight_load,
                       en_ifmap_load, en_psum, clear_psum, en_output, done_select, perf_cycles};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t blank(input int c);
        ev_t e;
        e = '0;
        e.cyc = c;
        return e;
    endfunction

    // Reference: the event sequence of a whole tile, derived from the tile's loop structure.
    function automatic void push_tile(input int t, input logic [WA-1:0] wb, input int ib, input int len,
                                      input int nch, input bit hold_k7);
        ev_t e;
        int c;
        logic [NB-1:0] one;
        logic [IA-1:0] a;
        one = 1;
        if (len == 0 || nch == 0) begin
            e = blank(t + 1); e.done = 1'b1; exp_q.push_back(e);
            return;
        end
        e = blank(t + 1); e.w_re = '1; e.w_flat = {NB{wb}}; exp_q.push_back(e);
        e = blank(t + 1 + RL); e.ewl = '1; exp_q.push_back(e);
        c = t + 2 + RL;
        for (int ch = 0; ch < nch; ch++) begin
            for (int i = 0; i < len; i++) begin
                a = IA'((ib + i) % (1 << IA));
                e = blank(c); e.if_re = one << ch; e.if_flat = {NB{a}}; e.sel = SW'(ch); e.clr = '1;
                exp_q.push_back(e);
                e = blank(c + RL); e.eil = '1; e.eps = '1; exp_q.push_back(e);
                c = c + RL + 1;
                for (int k = 0; k < NB; k++) begin
                    e = blank(c); e.eout = one << k; e.dsel = (SW+1)'(k); exp_q.push_back(e);
                    c = c + 1;
                    if (hold_k7 && ch == 0 && i == 0 && k == 7) c = c + 3;
                end
            end
        end
        e = blank(c); e.done = 1'b1; exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a strobe or done must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        if (!rst && (|w_re || |if_re || |en_weight_load || |en_ifmap_load || |en_psum || |clear_psum ||
                     |en_output || done)) begin
            a = blank(cyc);
            a.w_re = w_re;
            if (|w_re) a.w_flat = w_addr_rd_flat;
            a.if_re = if_re;
            if (|if_re) begin
                a.if_flat = if_addr_rd_flat;
                a.sel = ifmap_sel;
            end
            a.ewl = en_weight_load; a.eil = en_ifmap_load; a.eps = en_psum;
            a.clr = clear_psum; a.eout = en_output;
            if (|en_output) a.dsel = done_select;
            a.done = done;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d actual=%h required=none", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL event cyc=%0d actual=%h required=%h", cyc, a, e);
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_in_done actual=%b required=1", busy);
                end
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: plain, 1: hold after drain column 7, 2: stray start mid-tile, 3: reset mid-drain
    task automatic run_tile(input logic [WA-1:0] wb, input int ib, input int len, input int nch,
                            input int mode, output int t);
        int d0, exp_done;
        @(posedge clk); #1;
        cfg_w_base = wb; cfg_if_base = IA'(ib); cfg_len = IA'(len); cfg_num_ch = (SW+1)'(nch);
        start = 1'b1;
        t = cyc;
        d0 = done_cnt;
        push_tile(t, wb, ib, len, nch, mode == 1);
        exp_done = (len == 0 || nch == 0) ? t + 1 : t + 2 + RL + nch * len * E + ((mode == 1) ? 3 : 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        cfg_w_base = WA'($urandom); cfg_if_base = IA'($urandom);
        cfg_len = IA'($urandom); cfg_num_ch = (SW+1)'($urandom_range(0, NB));
        if (mode == 1) begin
            wait_until(t + 10 + 2 * RL);
            hold = 1'b1;
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                if (j == 2) hold = 1'b0;
                chk("hold_done_select", done_select, 7);
                chk("hold_en_output", en_output, 0);
            end
        end
        if (mode == 2) begin
            wait_until(t + 5);
            start = 1'b1;
            cfg_w_base = WA'($urandom); cfg_if_base = IA'($urandom); cfg_len = IA'($urandom_range(1, 3));
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (mode == 3) begin
            wait_until(t + 6 + 2 * RL);
            chk("mid_tile_busy", busy, 1);
            @(negedge clk); #1;
            rst = 1'b1;
            #1;
            chk("abort_outputs_zero", any_out, 0);
            exp_q.delete();
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            chk("idle_after_abort", {busy, done}, 0);
            chk("no_done_after_abort", done_cnt - d0, 0);
            return;
        end
        wait_until(exp_done + 2);
        chk("done_count", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_cycle", last_done_cyc, exp_done);
`ifdef TCONV_SEQ_PERF_EN
        chk("perf_cycles", perf_cycles, exp_done - t - 1);
`else
        chk("perf_cycles_tied", perf_cycles, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", any_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy, done}, 0);

        run_tile(10'd5, 10, 3, 2, 0, t);
        chk("first_tile_done_offset", last_done_cyc - t, 111);
`ifdef TCONV_SEQ_PERF_EN
        chk("first_tile_perf", perf_cycles, 110);
`endif
        run_tile(10'd77, 1022, 4, 1, 0, t);
        run_tile(10'd3, 50, 0, 2, 0, t);
        run_tile(10'd3, 50, 2, 0, 0, t);
        run_tile(10'd9, 200, 2, 1, 1, t);
        run_tile(10'd7, 100, 2, 2, 2, t);
        run_tile(10'd11, 300, 2, 2, 3, t);
        run_tile(10'd12, 400, 1, 3, 0, t);
        for (int n = 0; n < 8; n++) begin
            run_tile(WA'($urandom), $urandom_range(900, 1023), $urandom_range(0, 3), $urandom_range(0, NB), 0, t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
